// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter and any future bus masters (DMA).
package bus_pkg;

    localparam int   AW_DEF = 3;
    localparam int   DW_DEF = 8;
    localparam logic BUS_Z  = 1'bz;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_i[i] && (((int'(ptr_i) + off) % N) == i)) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises requester transactions onto the shared tri-state bus, round-robin between requesters.
// state | meaning
// IDLE  | no owner; pick winner when any req is high
// XFER  | strobe (dbin or we) held for WAIT_CYCLES cycles
// ACK   | one-cycle ack to owner, pointer advances past owner
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_wr,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                busy,
    output logic [AW-1:0]       addr_bus,
    inout  wire  [DW-1:0]       data_bus,
    output logic                dbin,
    output logic                we
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("bus_arbiter: WAIT_CYCLES must be at least 1");
        end
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
            $error("bus_arbiter: N_REQ must be in 2..8");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]  arb_gnt;
    logic [PW-1:0]     owner_idx;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) owner_idx = PW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d = arb_gnt;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            wr_d    = req_wr[i];
                            addr_d  = req_addr[i*AW +: AW];
                            wdata_d = req_wdata[i*DW +: DW];
                        end
                    end
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                    state_d = XFER;
                end
            end
            XFER: begin
                if (cnt_q == '0) begin
                    // Sources drive the bus for the whole strobe; sample on its last edge.
                    if (!wr_q) rdata_d = data_bus;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACK: begin
                ptr_d   = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + PW'(1);
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign busy     = (state_q != IDLE);
    assign dbin     = (state_q == XFER) && !wr_q;
    assign we       = (state_q == XFER) && wr_q;
    assign data_bus = we ? wdata_q : {DW{BUS_Z}};
    assign gnt      = gnt_q;
    assign ack      = (state_q == ACK) ? gnt_q : '0;
    assign rdata    = rdata_q;
    assign addr_bus = addr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two sources (0->aa, 4->55), one sink, scoreboard per requester.
module tb_bus_arbiter;

    localparam int W = 1;

    typedef struct packed {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req_wr, gnt, ack;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  rdata;
    logic        busy, dbin, we;
    logic [2:0]  addr_bus;
    wire  [7:0]  data_bus;

    logic [1:0]  req3, req3_wr, gnt3, ack3;
    logic [5:0]  req3_addr;
    logic [15:0] req3_wdata;
    logic [7:0]  rdata3;
    logic        busy3, dbin3, we3;
    logic [2:0]  addr_bus3;
    wire  [7:0]  data_bus3;

    always #5 clk = ~clk;

    bus_arbiter #(.N_REQ(2), .AW(3), .DW(8), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .addr_bus(addr_bus), .data_bus(data_bus), .dbin(dbin), .we(we)
    );

    bus_arbiter #(.N_REQ(2), .AW(3), .DW(8), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_wr(req3_wr), .req_addr(req3_addr),
        .req_wdata(req3_wdata), .gnt(gnt3), .ack(ack3), .rdata(rdata3), .busy(busy3),
        .addr_bus(addr_bus3), .data_bus(data_bus3), .dbin(dbin3), .we(we3)
    );

    assign data_bus  = (dbin && addr_bus == 3'd0) ? 8'haa :
                       (dbin && addr_bus == 3'd4) ? 8'h55 : 8'hzz;
    assign data_bus3 = (dbin3 && addr_bus3 == 3'd0) ? 8'haa :
                       (dbin3 && addr_bus3 == 3'd4) ? 8'h55 : 8'hzz;

    int   total = 0;
    int   bad   = 0;
    exp_t expq[2][$];
    logic [1:0] outst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] src_val(input logic [2:0] a);
        return (a == 3'd0) ? 8'haa : (a == 3'd4) ? 8'h55 : 8'h00;
    endfunction

    task automatic issue(input int i, input logic wr, input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        e.wr   = wr;
        e.addr = a;
        e.data = wr ? d : src_val(a);
        expq[i].push_back(e);
        req_wr[i]           = wr;
        req_addr[i*3 +: 3]  = a;
        req_wdata[i*8 +: 8] = d;
        req[i]              = 1'b1;
    endtask

    task automatic wait_gnt(input int i);
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (gnt[i]) seen = 1;
        end
        if (!seen) chk("gnt_timeout", 32'(gnt), 32'(1 << i));
    endtask

    task automatic wait_ack(input int i, output int lat);
        bit seen = 0;
        lat = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            lat++;
            if (ack[i]) begin
                seen   = 1;
                req[i] = 1'b0;
            end
        end
        if (!seen) chk("ack_timeout", 32'(ack), 32'(1 << i));
    endtask

    // Monitor: independent round-robin reference and per-requester scoreboard.
    int         rr_m, xfer_n, m_own;
    logic [1:0] req_p, ack_p, exp_g, g_exp;
    logic       busy_p;
    logic [7:0] last_rd, sink_val;
    logic [2:0] sink_addr;
    exp_t       m_e;

    always @(negedge clk) begin
        if (rst) begin
            rr_m    = 0;
            busy_p  = 1'b0;
            ack_p   = '0;
            req_p   = '0;
            last_rd = '0;
            xfer_n  = 0;
            chk("ack_in_reset", 32'(ack), 32'd0);
        end else begin
            chk("strobe_excl", 32'(dbin & we), 32'd0);
            if (ack_p != '0) chk("ack_width", 32'(ack), 32'd0);
            if (busy && !busy_p) begin
                exp_g = '0;
                for (int k = 0; k < 2; k++) begin
                    if (exp_g == '0 && req_p[(rr_m + k) % 2]) exp_g[(rr_m + k) % 2] = 1'b1;
                end
                g_exp = exp_g;
                chk("grant", 32'(gnt), 32'(exp_g));
                xfer_n = 0;
            end
            if (dbin || we) xfer_n++;
            if (we) begin
                sink_val  = data_bus;
                sink_addr = addr_bus;
            end
            if (ack != '0) begin
                m_own = ack[1] ? 1 : 0;
                chk("ack_owner", 32'(ack), 32'(g_exp));
                chk("xfer_len", 32'(xfer_n), 32'(W));
                if (expq[m_own].size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    m_e = expq[m_own].pop_front();
                    if (m_e.wr) begin
                        chk("sink_data", 32'(sink_val), 32'(m_e.data));
                        chk("sink_addr", 32'(sink_addr), 32'(m_e.addr));
                    end else begin
                        last_rd = m_e.data;
                    end
                    chk("rdata", 32'(rdata), 32'(last_rd));
                end
                rr_m = (m_own + 1) % 2;
            end
            busy_p = busy;
            ack_p  = ack;
            req_p  = req;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cyc, dcnt, ackcyc, seqv;
        int cnt[2];
        bit done;
        rst = 1'b1;
        req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        req3 = '0; req3_wr = '0; req3_addr = '0; req3_wdata = '0;
        outst = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(addr_bus), 32'd0);
        chk("rst_dbin", 32'(dbin), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_rdata3", 32'(rdata3), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: read addr 0 by requester 0
        issue(0, 1'b0, 3'd0, 8'h00);
        wait_gnt(0);
        chk("t1_dbin", 32'(dbin), 32'd1);
        chk("t1_we", 32'(we), 32'd0);
        chk("t1_addr", 32'(addr_bus), 32'd0);
        wait_ack(0, lat);
        chk("t1_ack_lat", 32'(lat), 32'(W));
        chk("t1_rdata", 32'(rdata), 32'haa);
        @(posedge clk); #1;

        // 2: write c3 to addr 2 by requester 1
        issue(1, 1'b1, 3'd2, 8'hc3);
        wait_gnt(1);
        chk("t2_we", 32'(we), 32'd1);
        chk("t2_dbin", 32'(dbin), 32'd0);
        chk("t2_bus", 32'(data_bus), 32'hc3);
        chk("t2_addr", 32'(addr_bus), 32'd2);
        wait_ack(1, lat);
        chk("t2_we_after", 32'(we), 32'd0);
        chk("t2_bus_released", 32'(data_bus == 8'hc3), 32'd0);
        @(posedge clk); #1;

        // 3: both requesting reads, req held across acks
        issue(0, 1'b0, 3'd0, 8'h00);
        issue(0, 1'b0, 3'd0, 8'h00);
        issue(1, 1'b0, 3'd4, 8'h00);
        issue(1, 1'b0, 3'd4, 8'h00);
        cnt[0] = 0; cnt[1] = 0; seqv = 0; done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    cnt[i]++;
                    seqv = (seqv << 4) | i;
                    if (cnt[i] == 2) req[i] = 1'b0;
                end
            end
            if (cnt[0] == 2 && cnt[1] == 2) done = 1;
        end
        chk("t3_rr_order", 32'(seqv), 32'h0101);
        @(posedge clk); #1;

        // 4: req dropped mid-transfer
        issue(0, 1'b0, 3'd4, 8'h00);
        wait_gnt(0);
        req[0] = 1'b0;
        wait_ack(0, lat);
        chk("t4_rdata", 32'(rdata), 32'h55);
        @(posedge clk); #1;

        // 5: reset in the middle of a write
        issue(1, 1'b1, 3'd2, 8'h5a);
        wait_gnt(1);
        #2 rst = 1'b1;
        #1;
        chk("t5_we", 32'(we), 32'd0);
        chk("t5_dbin", 32'(dbin), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_bus", 32'(data_bus == 8'h5a), 32'd0);
        req = '0;
        expq[0].delete();
        expq[1].delete();
        @(posedge clk); #1;
        chk("t5_no_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(0, 1'b0, 3'd0, 8'h00);
        issue(1, 1'b0, 3'd4, 8'h00);
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk); #1;
            if (gnt != '0) done = 1;
        end
        chk("t5_first_gnt", 32'(gnt), 32'd1);
        outst = 2'b11;
        for (int n = 0; n < 40 && outst != '0; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin req[i] = 1'b0; outst[i] = 1'b0; end
            end
            @(posedge clk); #1;
        end
        chk("t5_drain", 32'(outst), 32'd0);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    req[i]   = 1'b0;
                    outst[i] = 1'b0;
                end else if (outst[i]) begin
                    if (gnt[i]) begin
                        req_wr[i]           = 1'($urandom);
                        req_addr[i*3 +: 3]  = 3'($urandom);
                        req_wdata[i*8 +: 8] = 8'($urandom);
                        if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                    end
                end else if (c < 760 && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1)
                        issue(i, 1'b1, 3'($urandom), 8'($urandom));
                    else
                        issue(i, 1'b0, ($urandom_range(0, 1) == 1) ? 3'd4 : 3'd0, 8'h00);
                    outst[i] = 1'b1;
                end
            end
        end
        for (int n = 0; n < 60 && outst != '0; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin req[i] = 1'b0; outst[i] = 1'b0; end
            end
        end
        chk("rand_drain", 32'(outst), 32'd0);
        chk("rand_q0_empty", 32'(expq[0].size()), 32'd0);
        chk("rand_q1_empty", 32'(expq[1].size()), 32'd0);

        // 6: WAIT_CYCLES=3 instance, read addr 0
        @(posedge clk); #1;
        req3_wr[0] = 1'b0;
        req3_addr[2:0] = 3'd0;
        req3[0] = 1'b1;
        cyc = 0; dcnt = 0; ackcyc = 0; done = 0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (gnt3 != '0) begin
                cyc++;
                if (dbin3) dcnt++;
                if (ack3[0]) begin
                    ackcyc = cyc;
                    done   = 1;
                end
            end
        end
        req3[0] = 1'b0;
        chk("t6_dbin_cycles", 32'(dcnt), 32'd3);
        chk("t6_ack_cycle", 32'(ackcyc), 32'd4);
        chk("t6_rdata", 32'(rdata3), 32'haa);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
